// File: rtl/compute_unit_pipe.sv
// rtl/compute_unit_pipe.sv - single-issue register-to-register ALU with registered result channel
// Instructions execute in the accept cycle; results sit in a 1-deep output register with backpressure.
module compute_unit_pipe #(
    parameter int DATA_W = 8,
    parameter int REG_ADDR_W = 4,
    localparam int INSTR_W = 4 + 3*REG_ADDR_W + DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [REG_ADDR_W-1:0] out_tgt,
    output logic                  out_zero,
    output logic                  out_carry,
    output logic                  out_err,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] tgt, src0, src1;
    logic [DATA_W-1:0]     imm, a, b;
    logic [DATA_W:0]       sum, diff;
    logic [DATA_W-1:0]     res;
    logic                  carry, err, wb, emit, zero, accept;

    assign opcode = in_instr[INSTR_W-1 -: 4];
    assign tgt    = in_instr[DATA_W+3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign src0   = in_instr[DATA_W+2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign src1   = in_instr[DATA_W+REG_ADDR_W-1 -: REG_ADDR_W];
    assign imm    = in_instr[DATA_W-1:0];

    assign a    = regs[src0];
    assign b    = regs[src1];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        res   = '0;
        carry = 1'b0;
        err   = 1'b0;
        wb    = 1'b1;
        emit  = 1'b1;
        case (opcode)
            4'h0: begin wb = 1'b0; emit = 1'b0; end
            4'h1: res = imm;
            4'h2: begin res = sum[DATA_W-1:0]; carry = sum[DATA_W]; end
            4'h3: begin res = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
            4'h4: res = a & b;
            4'h5: res = a | b;
            4'h6: res = ~a;
            4'h7: res = a ^ b;
            4'h8: res = (b >= SHIFT_LIM) ? '0 : (a << b);
            4'h9: res = (b >= SHIFT_LIM) ? '0 : (a >> b);
            4'hA: res = a;
            4'hB: begin res = diff[DATA_W-1:0]; carry = diff[DATA_W]; wb = 1'b0; end
            default: begin err = 1'b1; wb = 1'b0; end
        endcase
        zero = (res == '0) && !err;
    end

    // Register reads above see pre-edge contents, so same-instruction tgt==src reads the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tgt   <= '0;
            out_zero  <= 1'b0;
            out_carry <= 1'b0;
            out_err   <= 1'b0;
            dbg_data  <= '0;
        end else begin
            dbg_data <= regs[dbg_addr];
            if (accept && wb) regs[tgt] <= res;
            if (accept && emit) begin
                out_valid <= 1'b1;
                out_data  <= res;
                out_tgt   <= tgt;
                out_zero  <= zero;
                out_carry <= carry;
                out_err   <= err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_compute_unit_pipe.sv
// tb/tb_compute_unit_pipe.sv - directed and random checks of compute_unit_pipe against an arithmetic model
module tb_compute_unit_pipe #(
    parameter int DW = 8,
    parameter int RA = 4
);
    localparam int NR = 1 << RA;
    localparam int IW = 4 + 3*RA + DW;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready;
    logic [IW-1:0] in_instr;
    logic [DW-1:0] out_data, dbg_data;
    logic [RA-1:0] out_tgt, dbg_addr;
    logic          out_zero, out_carry, out_err;

    compute_unit_pipe #(.DATA_W(DW), .REG_ADDR_W(RA)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tgt(out_tgt), .out_zero(out_zero), .out_carry(out_carry), .out_err(out_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] mreg [NR];
    logic [DW-1:0] last_d;
    logic [RA-1:0] last_t;
    logic          last_z, last_c, last_e, last_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the opcode table using plain integer arithmetic.
    task automatic model(input logic [3:0] op, input int t, input int s0, input int s1,
                         input longint imm, output logic emit);
        longint a, b, mask, d;
        logic c, e, wb;
        mask = (longint'(1) << DW) - 1;
        a = longint'(mreg[s0]);
        b = longint'(mreg[s1]);
        d = 0; c = 0; e = 0; wb = 1; emit = 1;
        case (op)
            4'h0: begin emit = 0; wb = 0; end
            4'h1: d = imm & mask;
            4'h2: begin d = (a + b) & mask; c = (a + b) > mask; end
            4'h3: begin d = (a - b) & mask; c = a < b; end
            4'h4: d = a & b;
            4'h5: d = a | b;
            4'h6: d = mask - a;
            4'h7: d = a ^ b;
            4'h8: d = (b >= DW) ? 0 : ((a << b) & mask);
            4'h9: d = (b >= DW) ? 0 : (a >> b);
            4'hA: d = a;
            4'hB: begin d = (a - b) & mask; c = a < b; wb = 0; end
            default: begin e = 1; wb = 0; end
        endcase
        if (emit) begin
            last_d = d[DW-1:0];
            last_t = RA'(t);
            last_c = c;
            last_e = e;
            last_z = (d == 0) && !e;
        end
        if (wb) mreg[t] = d[DW-1:0];
    endtask

    task automatic issue(input logic [3:0] op, input int t, input int s0, input int s1, input longint imm);
        logic emit;
        logic [DW-1:0] exp_dbg;
        in_instr  = {op, RA'(t), RA'(s0), RA'(s1), DW'(imm)};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_dbg   = mreg[dbg_addr];
        model(op, t, s0, s1, imm, emit);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("out_valid", 64'(out_valid), 64'(emit));
        if (emit) begin
            chk("out_data", 64'(out_data), 64'(last_d));
            chk("out_tgt", 64'(out_tgt), 64'(last_t));
            chk("out_zero", 64'(out_zero), 64'(last_z));
            chk("out_carry", 64'(out_carry), 64'(last_c));
            chk("out_err", 64'(out_err), 64'(last_e));
        end
        chk("dbg_prewrite", 64'(dbg_data), 64'(exp_dbg));
        last_valid = emit;
    endtask

    task automatic sweep(input string tag);
        in_valid = 1'b0;
        for (int i = 0; i < NR; i++) begin
            dbg_addr = RA'(i);
            @(posedge clk); #1;
            chk(tag, 64'(dbg_data), 64'(mreg[i]));
        end
        last_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] rop;
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        last_valid = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_flags", 64'({out_zero, out_carry, out_err}), 64'(0));
        chk("rst_dbg", 64'(dbg_data), 64'(0));

        // Back-to-back loads and dependent add.
        dbg_addr = RA'(7);
        issue(4'h1, 3, 0, 0, 'h2A);
        issue(4'h1, 5, 0, 0, 'h10);
        issue(4'h2, 7, 3, 5, 0);
        chk("add_3a", 64'(out_data), 64'h3A);
        @(posedge clk); #1;
        chk("dbg_r7", 64'(dbg_data), 64'h3A);

        // Carry, borrow and compare.
        issue(4'h1, 1, 0, 0, 'hF0);
        issue(4'h1, 2, 0, 0, 'h20);
        issue(4'h2, 4, 1, 2, 0);
        issue(4'h3, 4, 2, 1, 0);
        dbg_addr = RA'(4);
        issue(4'hB, 4, 1, 1, 0);
        chk("cmp_zero", 64'(out_zero), 64'(1));

        // Backpressure with a pending self-accumulating add.
        issue(4'h2, 4, 4, 1, 0);
        in_instr = {4'h2, RA'(4), RA'(4), RA'(1), DW'(0)};
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_data", 64'(out_data), 64'(last_d));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_no_write", 64'(dbg_data), 64'(mreg[4]));
        end
        issue(4'h2, 4, 4, 1, 0);
        issue(4'h0, 0, 0, 0, 0);

        // Same-register operands, then write visibility.
        dbg_addr = RA'(6);
        issue(4'h1, 6, 0, 0, 'h03);
        issue(4'h2, 6, 6, 6, 0);
        issue(4'h2, 6, 6, 6, 0);
        chk("r6_0c", 64'(out_data), 64'h0C);

        // Shift boundaries and an illegal opcode.
        issue(4'h1, 0, 0, 0, DW);
        issue(4'h1, 1, 0, 0, 'h80);
        issue(4'h8, 2, 1, 0, 0);
        issue(4'h1, 3, 0, 0, 7);
        issue(4'h9, 2, 1, 3, 0);
        chk("shr_1", 64'(out_data), 64'h01);
        issue(4'hE, 1, 2, 3, 'hFF);
        sweep("illegal_regs");

        // Reset while a result is pending.
        issue(4'h1, 5, 0, 0, 'h55);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_outs", 64'({out_data, out_tgt, out_zero, out_carry, out_err}), 64'(0));
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        sweep("rst_regs");

        // Random traffic with idle and stall cycles.
        for (int n = 0; n < 400; n++) begin
            dbg_addr = RA'($urandom_range(0, NR-1));
            if ($urandom_range(0, 5) == 0) begin
                in_valid = 1'b0; out_ready = 1'b1;
                @(posedge clk); #1;
                chk("idle_valid", 64'(out_valid), 64'(0));
                last_valid = 1'b0;
            end else if (last_valid && $urandom_range(0, 3) == 0) begin
                in_instr = IW'($urandom);
                in_valid = 1'b1; out_ready = 1'b0;
                @(posedge clk); #1;
                in_valid = 1'b0;
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_data", 64'(out_data), 64'(last_d));
                chk("stall_tgt", 64'(out_tgt), 64'(last_t));
            end else begin
                rop = 4'($urandom_range(0, 15));
                issue(rop, $urandom_range(0, NR-1), $urandom_range(0, NR-1),
                      $urandom_range(0, NR-1),
                      ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, DW + 1))
                                                  : longint'($urandom));
            end
        end
        sweep("final_regs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/compute_unit_pipe.md
Name: compute_unit_pipe

Overview:
- Parametrised successor to the 8-bit, 16-register compute unit. Executes one register-to-register ALU instruction per cycle against an internal register file.
- Instruction input uses a valid/ready handshake. Each instruction's result, flags and error are returned on a registered valid/ready output channel with backpressure.
- Adds shifts, MOV, CMP, carry/zero flags, illegal-opcode reporting and a registered debug read port.
- Sits between the instruction source (pads or sequencer) and the output/display logic.

Parameters:
- DATA_W, 8, datapath and register width in bits (≥4, power of two).
- REG_ADDR_W, 4, register index width; NUM_REGS = 2**REG_ADDR_W.
- INSTR_W, 4+3*REG_ADDR_W+DATA_W, derived (localparam); do not override.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  unit can accept an instruction this cycle.
- in_instr  in  INSTR_W  {opcode[3:0], tgt, src0, src1, imm[DATA_W-1:0]}, MSB first.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  result value.
- out_tgt  out  REG_ADDR_W  target index of the instruction.
- out_zero  out  1  result == 0.
- out_carry  out  1  carry/borrow flag.
- out_err  out  1  illegal opcode.
- dbg_addr  in  REG_ADDR_W  debug read index.
- dbg_data  out  DATA_W  R[dbg_addr], registered (1-cycle latency).

Behaviour:
- Reset (rst=1 at a rising edge): all NUM_REGS registers cleared (every entry, no off-by-one). out_valid, out_data, out_tgt, out_zero, out_carry, out_err and dbg_data all go to 0.
- Reset mid-operation discards any pending result. in_ready is 0 while rst=1.
- Accept: accept = in_valid & in_ready, with in_ready = !out_valid | out_ready. This gives full throughput with a 1-deep output register.
- On accept, in one cycle:
  - read R[src0] and R[src1] (pre-write values);
  - compute;
  - write R[tgt] at the clock edge when the opcode writes back;
  - load the output register. out_valid=1 on the following cycle, so latency is 1 cycle.
- Read/write ordering:
  - tgt == src in the same instruction: the source reads the old value.
  - Back-to-back instructions: the second sees the first's writeback (the write completes before the next read).
- Backpressure: while out_valid & !out_ready, all out_* hold stable, in_ready=0 and no register write occurs.
- When out_ready=1 and no accept: out_valid clears next cycle.
- Opcodes (A=R[src0], B=R[src1]; all arithmetic is modulo 2**DATA_W):
  - 0 NOP: consumed, no writeback, no output (out_valid unaffected).
  - 1 LOAD: R[tgt]=imm; carry=0.
  - 2 ADD: A+B; carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - 3 SUB: A-B; carry = borrow (A<B unsigned).
  - 4 AND, 5 OR, 7 XOR: bitwise; carry=0.
  - 6 NOT: ~A (full-width bitwise); carry=0.
  - 8 SHL: A<<B; result 0 if B≥DATA_W; carry=0.
  - 9 SHR: A>>B logical; result 0 if B≥DATA_W; carry=0.
  - A MOV: R[tgt]=A; carry=0.
  - B CMP: computes A-B; flags as SUB; out_data=A-B; no writeback.
  - C–F illegal: no writeback; output emitted with out_data=0, out_zero=0, out_carry=0, out_err=1.
- out_zero = (result==0) for every legal opcode that emits output. out_err=0 for legal opcodes.
- dbg_data <= R[dbg_addr] every cycle (pre-write value, same ordering as ALU reads). It is not affected by backpressure.

Test Plan:
- Reset then LOAD R3=0x2A, LOAD R5=0x10, ADD R7=R3+R5 back-to-back with out_ready=1 → three outputs on consecutive cycles: 0x2A, 0x10, 0x3A. out_carry=0; dbg_addr=7 gives dbg_data=0x3A.
- LOAD R1=0xF0, R2=0x20; ADD R4=R1+R2 → out_data=0x10, carry=1. SUB R4=R2-R1 → 0x30, carry=1. CMP R1,R1 → 0x00, zero=1, R[tgt] unchanged.
- Hold out_ready=0 after ADD with in_valid=1 continuously → in_ready=0 and outputs stable for 5 cycles, no extra writebacks. Release → remaining instructions complete in order.
- tgt=src0=src1=R6 (R6=0x03), ADD → out_data=0x06. The next ADD R6 → 0x0C (write visible).
- SHL with B=DATA_W → 0. SHR 0x80 by 7 → 0x01. Opcode 0xE → out_err=1, out_data=0, no register changed (check via dbg).
- Assert rst for 1 cycle while out_valid=1 → next cycle out_valid=0, all registers read 0 via dbg_addr sweep 0..NUM_REGS-1. Rerun with DATA_W=16, REG_ADDR_W=3.
